// File: rtl/inport_handshake.sv
// inport_handshake: input stage for the picoMIPS cpu.
// Brings the board switches into the clock domain, debounces the "data ready"
// key, captures the operand on each debounced press and offers it to the cpu
// through a valid/ack handshake so every press is consumed exactly once.
module inport_handshake #(
    parameter int n   = 8,
    parameter int DEB = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] sw_data,
    input  logic         sw_ready,
    input  logic         in_ack,
    output logic [n-1:0] in_data,
    output logic         in_valid,
    output logic         overrun
);

    // Debounce counter width follows from DEB and is not meant to be overridden.
    localparam int CW = $clog2(DEB + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HELD     = 2'd1,
        HELD_REL = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    // Synchroniser chains for the key and the operand bits.
    logic         rdyMeta_q;
    logic         rdySync_q;
    logic [n-1:0] dataMeta_q;
    logic [n-1:0] dataSync_q;

    // Debounce state.
    logic          db_q;
    logic          db_d;
    logic          dbPrev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rise;

    // Post-reset arming: a key already down when reset lifts must be released
    // once before its presses count.
    logic [1:0] fill_q;
    logic       armed_q;

    // Handshake state and registered outputs.
    state_t       state_q;
    logic [n-1:0] inData_q;
    logic         inValid_q;
    logic         overrun_q;

    // Two-flop synchroniser on every asynchronous switch input.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdyMeta_q  <= 1'b0;
            rdySync_q  <= 1'b0;
            dataMeta_q <= '0;
            dataSync_q <= '0;
        end else begin
            rdyMeta_q  <= sw_ready;
            rdySync_q  <= rdyMeta_q;
            dataMeta_q <= sw_data;
            dataSync_q <= dataMeta_q;
        end
    end

    // The debounced level only moves after DEB consecutive disagreeing samples;
    // any agreeing sample restarts the count, so short glitches are absorbed.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (rdySync_q == db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            db_d  = rdySync_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debounce registers plus the delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            db_q     <= 1'b0;
            cnt_q    <= '0;
            dbPrev_q <= 1'b0;
        end else begin
            db_q     <= db_d;
            cnt_q    <= cnt_d;
            dbPrev_q <= db_q;
        end
    end

    assign rise = db_q & ~dbPrev_q;

    // Arm presses once the synchroniser holds real samples and both the raw
    // and debounced key read released.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
        end else begin
            if (fill_q != 2'd2) begin
                fill_q <= fill_q + 2'd1;
            end
            if ((fill_q == 2'd2) && !db_q && !rdySync_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    // Handshake FSM with registered data, valid and sticky overrun outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            inData_q  <= '0;
            inValid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise && armed_q) begin
                        inData_q  <= dataSync_q;
                        inValid_q <= 1'b1;
                        state_q   <= HELD;
                    end
                end
                HELD: begin
                    if (in_ack) begin
                        inValid_q <= 1'b0;
                        state_q   <= db_q ? WAIT_REL : IDLE;
                    end else if (!db_q) begin
                        state_q <= HELD_REL;
                    end
                end
                HELD_REL: begin
                    if (rise && in_ack) begin
                        inData_q <= dataSync_q;
                        state_q  <= HELD;
                    end else if (rise) begin
                        overrun_q <= 1'b1;
                        state_q   <= HELD;
                    end else if (in_ack) begin
                        inValid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                WAIT_REL: begin
                    if (!db_q) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_data  = inData_q;
    assign in_valid = inValid_q;
    assign overrun  = overrun_q;

    // The counter must stay inside its range and valid must mirror the states
    // that hold unacknowledged data.
    always_ff @(posedge clk) begin
        if (reset) begin
            assert (cnt_q <= CNT_LAST);
            assert (inValid_q == ((state_q == HELD) || (state_q == HELD_REL)));
        end
    end

endmodule

// File: tb/tb_inport_handshake.sv
// tb_inport_handshake: directed bench for inport_handshake with DEB=4.
// A behavioural model of the key path (delay line, run-length debounce,
// press/consume rules) is compared with the DUT every cycle, and each
// scenario also pins hand-computed literal values.
module tb_inport_handshake;

    localparam int N   = 8;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] sw_data;
    logic         sw_ready;
    logic         in_ack;
    logic [N-1:0] in_data;
    logic         in_valid;
    logic         overrun;

    int checkCount = 0;
    int errorCount = 0;
    int capCount   = 0;
    logic prevValidMon = 1'b0;

    inport_handshake #(.n(N), .DEB(DEB)) dut (
        .clk      (clk),
        .reset    (reset),
        .sw_data  (sw_data),
        .sw_ready (sw_ready),
        .in_ack   (in_ack),
        .in_data  (in_data),
        .in_valid (in_valid),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive all inputs right after an edge, then let the given number of edges pass.
    task automatic applyStimulus(input logic rst, input logic rdy, input logic [N-1:0] dat,
                                 input logic ack, input int cycles);
        reset    = rst;
        sw_ready = rdy;
        sw_data  = dat;
        in_ack   = ack;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Behavioural model state.
    logic         mSync1 = 0, mSync2 = 0, mDb = 0, mRisePending = 0;
    logic         mArmed = 0, mValid = 0, mOvr = 0, mWaitRel = 0;
    logic [N-1:0] mDat1 = 0, mDat2 = 0, mData = 0;
    int           mRun = 0, mFill = 0;
    bit           mLive = 0;

    // Model: two-sample delay, debounce as "DEB consecutive disagreeing samples",
    // and press/consume rules expressed as valid / waiting-for-release flags.
    always @(posedge clk) begin : modelProc
        logic rise;
        if (!reset) begin
            mSync1 = 0; mSync2 = 0; mDb = 0; mRisePending = 0;
            mArmed = 0; mValid = 0; mOvr = 0; mWaitRel = 0;
            mDat1 = 0; mDat2 = 0; mData = 0; mRun = 0; mFill = 0;
            mLive = 1;
        end else begin
            rise = mRisePending;
            if (mValid) begin
                if (rise) begin
                    if (in_ack) mData = mDat2;
                    else        mOvr  = 1;
                end else if (in_ack) begin
                    mValid   = 0;
                    mWaitRel = mDb;
                end
            end else if (mWaitRel) begin
                if (!mDb) mWaitRel = 0;
            end else if (rise && mArmed) begin
                mData  = mDat2;
                mValid = 1;
            end
            if (mFill == 2 && !mDb && !mSync2) mArmed = 1;
            if (mFill < 2) mFill++;
            mRisePending = 0;
            if (mSync2 != mDb) begin
                mRun++;
                if (mRun == DEB) begin
                    mDb = mSync2;
                    mRun = 0;
                    mRisePending = mDb;
                end
            end else begin
                mRun = 0;
            end
            mSync2 = mSync1;
            mSync1 = sw_ready;
            mDat2  = mDat1;
            mDat1  = sw_data;
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        if (mLive) begin
            checkOutput("cmp in_data", 32'(in_data), 32'(mData));
            checkOutput("cmp in_valid", 32'(in_valid), 32'(mValid));
            checkOutput("cmp overrun", 32'(overrun), 32'(mOvr));
        end
    end

    // Count DUT captures seen as in_valid rising.
    always @(negedge clk) begin
        if (in_valid && !prevValidMon) capCount++;
        prevValidMon = in_valid;
    end

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int capBase;
        reset = 1'b0; sw_ready = 1'b0; sw_data = '0; in_ack = 1'b0;

        // 1: reset held with toggling inputs
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, k[0], N'($urandom), ~k[0], 1);
            checkOutput("t1 in_data", 32'(in_data), 32'h00);
            checkOutput("t1 in_valid", 32'(in_valid), 32'd0);
            checkOutput("t1 overrun", 32'(overrun), 32'd0);
        end
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8);
        checkOutput("t1 release valid", 32'(in_valid), 32'd0);
        checkOutput("t1 release data", 32'(in_data), 32'h00);

        // 2: clean press, 7-cycle latency, single ack, no second capture
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0, 1);
            checkOutput("t2 latency valid", 32'(in_valid), 32'(k == 7));
        end
        checkOutput("t2 data", 32'(in_data), 32'h5A);
        applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0, 3);
        applyStimulus(1'b1, 1'b1, 8'h5A, 1'b1, 1);
        checkOutput("t2 ack drops valid", 32'(in_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0, 9);
        checkOutput("t2 no recapture", 32'(in_valid), 32'd0);
        checkOutput("t2 data kept", 32'(in_data), 32'h5A);
        applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0, 10);

        // 3: bounce then stable gives one capture; 3-cycle pulse gives none
        capBase = capCount;
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 8'h3C, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 8'h3C, 1'b0, 1);
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b0, 12);
        checkOutput("t3 bounce valid", 32'(in_valid), 32'd1);
        checkOutput("t3 bounce data", 32'(in_data), 32'h3C);
        checkOutput("t3 capture count", 32'(capCount - capBase), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'h3C, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 8'h3C, 1'b0, 10);
        capBase = capCount;
        applyStimulus(1'b1, 1'b1, 8'h3D, 1'b0, 3);
        applyStimulus(1'b1, 1'b0, 8'h3D, 1'b0, 15);
        checkOutput("t3 short pulse valid", 32'(in_valid), 32'd0);
        checkOutput("t3 short pulse count", 32'(capCount - capBase), 32'd0);

        // 5: in HELD_REL a new press coincident with ack replaces the data
        applyStimulus(1'b1, 1'b1, 8'h21, 1'b0, 8);
        checkOutput("t5 first data", 32'(in_data), 32'h21);
        applyStimulus(1'b1, 1'b0, 8'h21, 1'b0, 8);
        applyStimulus(1'b1, 1'b1, 8'h33, 1'b0, 6);
        applyStimulus(1'b1, 1'b1, 8'h33, 1'b1, 1);
        checkOutput("t5 valid stays", 32'(in_valid), 32'd1);
        checkOutput("t5 new data", 32'(in_data), 32'h33);
        checkOutput("t5 no overrun", 32'(overrun), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h33, 1'b0, 1);
        checkOutput("t5 still valid", 32'(in_valid), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'h33, 1'b1, 1);
        checkOutput("t5 ack drops valid", 32'(in_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h33, 1'b0, 10);

        // 4: press while unacked sets sticky overrun, data preserved
        applyStimulus(1'b1, 1'b1, 8'h11, 1'b0, 8);
        checkOutput("t4 first data", 32'(in_data), 32'h11);
        applyStimulus(1'b1, 1'b0, 8'h11, 1'b0, 8);
        applyStimulus(1'b1, 1'b1, 8'h22, 1'b0, 10);
        checkOutput("t4 overrun set", 32'(overrun), 32'd1);
        checkOutput("t4 data kept", 32'(in_data), 32'h11);
        checkOutput("t4 valid", 32'(in_valid), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'h22, 1'b1, 1);
        checkOutput("t4 ack drops valid", 32'(in_valid), 32'd0);
        checkOutput("t4 overrun sticky", 32'(overrun), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h22, 1'b0, 10);

        // 6: reset mid-handshake, key held through reset must be re-pressed
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 8);
        checkOutput("t6 captured", 32'(in_data), 32'h77);
        applyStimulus(1'b0, 1'b1, 8'h77, 1'b0, 2);
        checkOutput("t6 reset data", 32'(in_data), 32'h00);
        checkOutput("t6 reset valid", 32'(in_valid), 32'd0);
        checkOutput("t6 reset overrun", 32'(overrun), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 20);
        checkOutput("t6 held key ignored", 32'(in_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h77, 1'b0, 10);
        checkOutput("t6 released", 32'(in_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 8'h78, 1'b0, 8);
        checkOutput("t6 repress valid", 32'(in_valid), 32'd1);
        checkOutput("t6 repress data", 32'(in_data), 32'h78);
        applyStimulus(1'b1, 1'b1, 8'h78, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 8'h78, 1'b0, 10);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
